// File: rtl/ex_unit_seq.sv
// ex_unit_seq: RV32I/RV64I execute stage (ALU, branch/jump, AGU) plus an iterative
// shift-add multiplier. Define EX_DIV_EN to add the restoring divider (DIV/DIVU/REM/REMU).
module ex_unit_seq #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            kill,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            rd_we,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            illegal
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1} state_t;
`endif

  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic lt_s(input logic signed [XLEN-1:0] a, input logic signed [XLEN-1:0] b);
    return a < b;
  endfunction

  state_t          state_p1, state_d;
  logic [SHW-1:0]  cnt_p1, cnt_d;
  logic [XLEN-1:0] acc_p1, lo_p1, opb_p1;
  logic            res_neg_p1, sel_hi_p1;

  logic accept, m_op, mul_start, div_start, multi_start;
  logic a_sgn, b_sgn, a_neg, b_neg, sel_hi_d, res_neg_d;

  assign in_ready    = (state_p1 == IDLE);
  assign accept      = in_valid & in_ready & ~kill;
  assign m_op        = (opcode == OPC_OP) && (funct7 == 7'b0000001);
  assign mul_start   = accept & m_op & ~funct3[2];
`ifdef EX_DIV_EN
  assign div_start   = accept & m_op & funct3[2];
`else
  assign div_start   = 1'b0;
`endif
  assign multi_start = mul_start | div_start;

  // Operand signedness per variant: MUL/MULH/MULHSU/MULHU, then DIV/DIVU/REM/REMU.
  assign a_sgn     = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_sgn     = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign sel_hi_d  = funct3[2] ? funct3[1]  : (funct3[1:0] != 2'b00);
  assign a_neg     = a_sgn & rs1_val[XLEN-1];
  assign b_neg     = b_sgn & rs2_val[XLEN-1];
  // A zero divisor must give an all-ones quotient regardless of dividend sign.
  assign res_neg_d = funct3[2] ? ((a_neg ^ b_neg) & (|rs2_val)) : (a_neg ^ b_neg);

  // Single-cycle ALU
  logic [XLEN-1:0]        op_b, alu_res, sra_res, addr_sum, jalr_sum;
  logic signed [XLEN-1:0] rs1_s;
  logic [SHW-1:0]         shamt;
  logic                   sub_en, op_legal;

  assign op_b     = (opcode == OPC_OP) ? rs2_val : imm;
  assign shamt    = op_b[SHW-1:0];
  assign rs1_s    = rs1_val;
  assign sra_res  = rs1_s >>> shamt;
  assign sub_en   = (opcode == OPC_OP) && funct7[5];
  assign op_legal = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
  assign addr_sum = rs1_val + imm;
  assign jalr_sum = rs1_val + imm;

  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = sub_en ? rs1_val - op_b : rs1_val + op_b;
      3'b001:  alu_res = rs1_val << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s(rs1_val, op_b)};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, rs1_val < op_b};
      3'b100:  alu_res = rs1_val ^ op_b;
      3'b101:  alu_res = funct7[5] ? sra_res : rs1_val >> shamt;
      3'b110:  alu_res = rs1_val | op_b;
      default: alu_res = rs1_val & op_b;
    endcase
  end

  // Multiplier step: add multiplicand when the low multiplier bit is set, then shift right.
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_acc_n, mul_lo_n, mul_res;
  logic [2*XLEN-1:0] mul_fin;

  assign mul_sum   = {1'b0, acc_p1} + (lo_p1[0] ? {1'b0, opb_p1} : '0);
  assign mul_acc_n = mul_sum[XLEN:1];
  assign mul_lo_n  = {mul_sum[0], lo_p1[XLEN-1:1]};
  assign mul_fin   = cneg2({mul_acc_n, mul_lo_n}, res_neg_p1);
  assign mul_res   = sel_hi_p1 ? mul_fin[2*XLEN-1:XLEN] : mul_fin[XLEN-1:0];

`ifdef EX_DIV_EN
  // Restoring divider step: shift in next dividend bit, subtract divisor if it fits.
  logic            rem_neg_p1, div_ge;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff, div_acc_n, div_lo_n, div_res;

  assign div_shift = {acc_p1, lo_p1[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, opb_p1};
  assign div_diff  = div_shift[XLEN-1:0] - opb_p1;
  assign div_acc_n = div_ge ? div_diff : div_shift[XLEN-1:0];
  assign div_lo_n  = {lo_p1[XLEN-2:0], div_ge};
  assign div_res   = sel_hi_p1 ? cneg(div_acc_n, rem_neg_p1) : cneg(div_lo_n, res_neg_p1);
`endif

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_p1 <= IDLE;
      cnt_p1   <= '0;
    end else begin
      state_p1 <= state_d;
      cnt_p1   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_p1;
    cnt_d   = cnt_p1;
    case (state_p1)
      IDLE: begin
        if (mul_start) state_d = MUL;
`ifdef EX_DIV_EN
        if (div_start) state_d = DIV;
`endif
        if (multi_start) cnt_d = SHW'(XLEN-1);
      end
      default: begin
        cnt_d = cnt_p1 - SHW'(1);
        if (cnt_p1 == '0) state_d = IDLE;
      end
    endcase
    if (kill) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // FSM: completion outputs, registered below
  logic            done;
  logic [XLEN-1:0] res_d, tgt_d;
  logic            we_d, bt_d, ill_d;

  always_comb begin
    done  = 1'b0;
    res_d = '0;
    we_d  = 1'b0;
    bt_d  = 1'b0;
    tgt_d = br_target;
    ill_d = 1'b0;
    case (state_p1)
      IDLE: begin
        if (accept && !multi_start) begin
          done = 1'b1;
          case (opcode)
            OPC_OPIMM: begin res_d = alu_res; we_d = 1'b1; end
            OPC_OP: begin
              if (op_legal) begin
                res_d = alu_res;
                we_d  = 1'b1;
              end else begin
                ill_d = 1'b1;
              end
            end
            OPC_LUI:   begin res_d = imm;      we_d = 1'b1; end
            OPC_AUIPC: begin res_d = pc + imm; we_d = 1'b1; end
            OPC_JAL: begin
              res_d = pc + XLEN'(4);
              tgt_d = pc + imm;
              bt_d  = 1'b1;
              we_d  = 1'b1;
            end
            OPC_JALR: begin
              res_d = pc + XLEN'(4);
              tgt_d = {jalr_sum[XLEN-1:1], 1'b0};
              bt_d  = 1'b1;
              we_d  = 1'b1;
            end
            OPC_BRANCH: begin
              tgt_d = pc + imm;
              case (funct3)
                3'b000:  bt_d = (rs1_val == rs2_val);
                3'b001:  bt_d = (rs1_val != rs2_val);
                3'b100:  bt_d = lt_s(rs1_val, rs2_val);
                3'b101:  bt_d = ~lt_s(rs1_val, rs2_val);
                3'b110:  bt_d = (rs1_val < rs2_val);
                3'b111:  bt_d = (rs1_val >= rs2_val);
                default: ill_d = 1'b1;
              endcase
            end
            OPC_LOAD:  begin res_d = addr_sum; we_d = 1'b1; end
            OPC_STORE: res_d = addr_sum;
            default:   ill_d = 1'b1;
          endcase
        end
      end
      MUL: begin
        if (cnt_p1 == '0) begin
          done  = 1'b1;
          res_d = mul_res;
          we_d  = 1'b1;
        end
      end
`ifdef EX_DIV_EN
      DIV: begin
        if (cnt_p1 == '0) begin
          done  = 1'b1;
          res_d = div_res;
          we_d  = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Iteration registers
  always_ff @(posedge CLK) begin
    if (state_p1 == IDLE) begin
      if (multi_start) begin
        acc_p1     <= '0;
        lo_p1      <= cneg(rs1_val, a_neg);
        opb_p1     <= cneg(rs2_val, b_neg);
        res_neg_p1 <= res_neg_d;
        sel_hi_p1  <= sel_hi_d;
`ifdef EX_DIV_EN
        rem_neg_p1 <= a_neg;
`endif
      end
    end else if (state_p1 == MUL) begin
      acc_p1 <= mul_acc_n;
      lo_p1  <= mul_lo_n;
    end
`ifdef EX_DIV_EN
    else if (state_p1 == DIV) begin
      acc_p1 <= div_acc_n;
      lo_p1  <= div_lo_n;
    end
`endif
  end

  // Output stage
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      result    <= '0;
      rd_we     <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
      illegal   <= 1'b0;
    end else if (kill) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= done;
      if (done) begin
        result    <= res_d;
        rd_we     <= we_d;
        br_taken  <= bt_d;
        br_target <= tgt_d;
        illegal   <= ill_d;
      end
    end
  end

endmodule

// File: tb/tb_ex_unit_seq.sv
// Directed bench for ex_unit_seq (XLEN=32): table of single-cycle vectors plus
// hand-written multiply/divide, kill and reset sequences.
module tb_ex_unit_seq;
  localparam logic [6:0] OP  = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BR  = 7'b1100011, LD = 7'b0000011, ST = 7'b0100011;

  logic        CLK, RST, in_valid, in_ready, kill;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, imm, pc;
  logic        out_valid, rd_we, br_taken, illegal;
  logic [31:0] result, br_target;

  ex_unit_seq #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .kill(kill),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
    .out_valid(out_valid), .result(result), .rd_we(rd_we),
    .br_taken(br_taken), .br_target(br_target), .illegal(illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, im, pcv, res, tgt;
    logic        cres, we, bt, ctgt, ill;
  } vec_t;

  vec_t vt[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic addv(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, b, im, pcv, res, input logic cres, we, bt,
                      input logic [31:0] tgt, input logic ctgt, ill);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b; v.im = im; v.pcv = pcv;
    v.res = res; v.cres = cres; v.we = we; v.bt = bt; v.tgt = tgt; v.ctgt = ctgt; v.ill = ill;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, b, im, pcv);
    opcode = opc; funct3 = f3; funct7 = f7;
    rs1_val = a; rs2_val = b; imm = im; pc = pcv;
    in_valid = 1'b1;
  endtask

  // Issue an M-extension op and check latency, stall length and result.
  task automatic run_m(input string nm, input logic [2:0] f3, input logic [31:0] a, b, exp);
    int cyc;
    int lowc;
    @(negedge CLK);
    drive(OP, f3, 7'h01, a, b, 32'h0, 32'h0);
    @(negedge CLK);
    in_valid = 1'b0;
    cyc  = 1;
    lowc = 0;
    while (!out_valid && cyc < 40) begin
      if (!in_ready) lowc++;
      @(negedge CLK);
      cyc++;
    end
    chk({nm, ".latency"}, cyc, 33);
    chk({nm, ".ready_low"}, lowc, 32);
    chk({nm, ".ready_at_done"}, {31'b0, in_ready}, 32'h1);
    chk({nm, ".result"}, result, exp);
    chk({nm, ".rd_we"}, {31'b0, rd_we}, 32'h1);
    chk({nm, ".illegal"}, {31'b0, illegal}, 32'h0);
  endtask

  initial begin
    int ovc;
    RST = 1'b1; kill = 1'b0; in_valid = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0;
    rs1_val = '0; rs2_val = '0; imm = '0; pc = '0;

    //   opc  f3     f7     rs1           rs2           imm           pc          result       cres we bt tgt         ctgt ill
    addv(OPI, 3'd0, 7'h00, 32'd5,        32'd0,        32'hFFFFFFF9, 32'h1000, 32'hFFFFFFFE, 1, 1, 0, 32'h0,      0, 0);
    addv(OP,  3'd0, 7'h20, 32'd3,        32'd5,        32'h0,        32'h1000, 32'hFFFFFFFE, 1, 1, 0, 32'h0,      0, 0);
    addv(OP,  3'd1, 7'h00, 32'd1,        32'h23,       32'h0,        32'h1000, 32'h8,        1, 1, 0, 32'h0,      0, 0);
    addv(OP,  3'd2, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h1000, 32'h1,        1, 1, 0, 32'h0,      0, 0);
    addv(OP,  3'd3, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h1000, 32'h0,        1, 1, 0, 32'h0,      0, 0);
    addv(OP,  3'd5, 7'h20, 32'h80000000, 32'd4,        32'h0,        32'h1000, 32'hF8000000, 1, 1, 0, 32'h0,      0, 0);
    addv(OPI, 3'd5, 7'h00, 32'h80000000, 32'd0,        32'h4,        32'h1000, 32'h08000000, 1, 1, 0, 32'h0,      0, 0);
    addv(OPI, 3'd5, 7'h20, 32'h80000000, 32'd0,        32'h404,      32'h1000, 32'hF8000000, 1, 1, 0, 32'h0,      0, 0);
    addv(OP,  3'd4, 7'h00, 32'hF0F0,     32'hFF00,     32'h0,        32'h1000, 32'h0FF0,     1, 1, 0, 32'h0,      0, 0);
    addv(OPI, 3'd7, 7'h00, 32'h1234,     32'd0,        32'hFF,       32'h1000, 32'h34,       1, 1, 0, 32'h0,      0, 0);
    addv(OP,  3'd6, 7'h00, 32'h10,       32'h01,       32'h0,        32'h1000, 32'h11,       1, 1, 0, 32'h0,      0, 0);
    addv(LUI, 3'd0, 7'h00, 32'd0,        32'd0,        32'h12345000, 32'h1000, 32'h12345000, 1, 1, 0, 32'h0,      0, 0);
    addv(AUI, 3'd0, 7'h00, 32'd0,        32'd0,        32'h2000,     32'h1000, 32'h3000,     1, 1, 0, 32'h0,      0, 0);
    addv(JAL, 3'd0, 7'h00, 32'd0,        32'd0,        32'h20,       32'h1000, 32'h1004,     1, 1, 1, 32'h1020,   1, 0);
    addv(JALR,3'd0, 7'h00, 32'h2001,     32'd0,        32'h4,        32'h100,  32'h104,      1, 1, 1, 32'h2004,   1, 0);
    addv(BR,  3'd6, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h40,       32'h1000, 32'h0,        0, 0, 0, 32'h1040,   1, 0);
    addv(BR,  3'd4, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h40,       32'h1000, 32'h0,        0, 0, 1, 32'h1040,   1, 0);
    addv(BR,  3'd0, 7'h00, 32'd7,        32'd7,        32'h80,       32'h2000, 32'h0,        0, 0, 1, 32'h2080,   1, 0);
    addv(BR,  3'd1, 7'h00, 32'd7,        32'd7,        32'h80,       32'h2000, 32'h0,        0, 0, 0, 32'h2080,   1, 0);
    addv(BR,  3'd5, 7'h00, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFF0, 32'h2000, 32'h0,        0, 0, 0, 32'h1FF0,   1, 0);
    addv(BR,  3'd7, 7'h00, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFF0, 32'h2000, 32'h0,        0, 0, 1, 32'h1FF0,   1, 0);
    addv(BR,  3'd2, 7'h00, 32'd1,        32'd2,        32'h10,       32'h2000, 32'h0,        0, 0, 0, 32'h0,      0, 1);
    addv(LD,  3'd2, 7'h00, 32'h100,      32'd0,        32'hFFFFFFFC, 32'h1000, 32'hFC,       1, 1, 0, 32'h0,      0, 0);
    addv(ST,  3'd2, 7'h00, 32'h100,      32'd0,        32'h8,        32'h1000, 32'h108,      1, 0, 0, 32'h0,      0, 0);
    addv(7'h7F,3'd0,7'h00, 32'd1,        32'd1,        32'h0,        32'h1000, 32'h0,        0, 0, 0, 32'h0,      0, 1);
    addv(OP,  3'd1, 7'h20, 32'd1,        32'd1,        32'h0,        32'h1000, 32'h0,        0, 0, 0, 32'h0,      0, 1);
`ifndef EX_DIV_EN
    addv(OP,  3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h1000, 32'h0,        0, 0, 0, 32'h0,      0, 1);
`endif

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst.out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst.result", result, 32'h0);
    chk("rst.rd_we", {31'b0, rd_we}, 32'h0);
    chk("rst.br_taken", {31'b0, br_taken}, 32'h0);
    chk("rst.br_target", br_target, 32'h0);
    chk("rst.illegal", {31'b0, illegal}, 32'h0);
    chk("rst.in_ready", {31'b0, in_ready}, 32'h1);
    RST = 1'b0;

    // Single-cycle vector table
    foreach (vt[i]) begin
      @(negedge CLK);
      drive(vt[i].opc, vt[i].f3, vt[i].f7, vt[i].a, vt[i].b, vt[i].im, vt[i].pcv);
      @(negedge CLK);
      in_valid = 1'b0;
      chk($sformatf("v%0d.out_valid", i), {31'b0, out_valid}, 32'h1);
      if (vt[i].cres) chk($sformatf("v%0d.result", i), result, vt[i].res);
      chk($sformatf("v%0d.rd_we", i), {31'b0, rd_we}, {31'b0, vt[i].we});
      chk($sformatf("v%0d.br_taken", i), {31'b0, br_taken}, {31'b0, vt[i].bt});
      chk($sformatf("v%0d.illegal", i), {31'b0, illegal}, {31'b0, vt[i].ill});
      if (vt[i].ctgt) chk($sformatf("v%0d.br_target", i), br_target, vt[i].tgt);
      @(negedge CLK);
      chk($sformatf("v%0d.pulse_end", i), {31'b0, out_valid}, 32'h0);
    end

    // Multiplies
    run_m("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
    // Back-to-back issue in the completion cycle
    drive(OPI, 3'd0, 7'h00, 32'd10, 32'd0, 32'd5, 32'h0);
    @(negedge CLK);
    in_valid = 1'b0;
    chk("b2b.out_valid", {31'b0, out_valid}, 32'h1);
    chk("b2b.result", result, 32'd15);
    run_m("mulhu", 3'd3, 32'h80000000, 32'h80000000, 32'h40000000);
    run_m("mul", 3'd0, 32'h80000000, 32'h80000000, 32'h0);
    run_m("mulhsu", 3'd2, 32'h80000000, 32'h80000000, 32'hC0000000);
    run_m("mul_neg", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    run_m("mulh_neg", 3'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF);

`ifdef EX_DIV_EN
    run_m("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_m("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    run_m("rem_by0", 3'd6, 32'd7, 32'd0, 32'd7);
    run_m("divu_by0", 3'd5, 32'd7, 32'd0, 32'hFFFFFFFF);
    run_m("div_by0_neg", 3'd4, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF);
    run_m("div_neg", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_m("rem_neg", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_m("divu", 3'd5, 32'd100, 32'd7, 32'd14);
`endif

    // Kill mid-multiply at cycle 10
    @(negedge CLK);
    drive(OP, 3'd0, 7'h01, 32'd3, 32'd5, 32'h0, 32'h0);
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (9) @(negedge CLK);
    kill = 1'b1;
    @(negedge CLK);
    kill = 1'b0;
    chk("kill.out_valid", {31'b0, out_valid}, 32'h0);
    chk("kill.in_ready", {31'b0, in_ready}, 32'h1);
    ovc = 0;
    repeat (40) begin
      @(negedge CLK);
      if (out_valid) ovc++;
    end
    chk("kill.no_completion", ovc, 0);

    // Kill beats in_valid in the same cycle
    drive(OP, 3'd0, 7'h01, 32'd3, 32'd5, 32'h0, 32'h0);
    kill = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    kill = 1'b0;
    chk("kill_in.out_valid", {31'b0, out_valid}, 32'h0);
    chk("kill_in.in_ready", {31'b0, in_ready}, 32'h1);

    // Put nonzero values on the outputs, then reset mid-multiply at cycle 10
    drive(JAL, 3'd0, 7'h00, 32'd0, 32'd0, 32'h40, 32'h3000);
    @(negedge CLK);
    in_valid = 1'b0;
    chk("pre_rst.result", result, 32'h3004);
    drive(OP, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_mul.out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_mul.result", result, 32'h0);
    chk("rst_mul.rd_we", {31'b0, rd_we}, 32'h0);
    chk("rst_mul.br_taken", {31'b0, br_taken}, 32'h0);
    chk("rst_mul.br_target", br_target, 32'h0);
    chk("rst_mul.illegal", {31'b0, illegal}, 32'h0);
    chk("rst_mul.in_ready", {31'b0, in_ready}, 32'h1);
    ovc = 0;
    repeat (40) begin
      @(negedge CLK);
      if (out_valid) ovc++;
    end
    chk("rst_mul.no_completion", ovc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
